axil_master_bridge: RTL and testbench

- Initiator end of the AXI-Lite fabric: converts the PicoRV32-style native memory handshake (mem_valid/mem_ready) into single AXI-Lite master transactions.
- Drives the upstream 1->2 interconnect, which feeds the peripheral subsystem and its 1->4 decoder.
- One outstanding transaction at a time; registered outputs on both sides.
- Slave-response timeout reports an error to the CPU while keeping the AXI side protocol-compliant.

---
 rtl/axil_master_bridge_if.sv | 52 +++++
 rtl/axil_master_bridge.sv | 189 ++++++++++++++++++
 tb/tb_axil_master_bridge.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_master_bridge_if.sv
// Bundle of the CPU native memory handshake and the AXI-Lite master channels.
// master = bridge side, slave = CPU + AXI-Lite fabric side.
interface axil_master_bridge_if;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_err;

   logic [31:0] M_AWADDR;
   logic [2:0]  M_AWPROT;
   logic        M_AWVALID;
   logic        M_AWREADY;
   logic [31:0] M_WDATA;
   logic [3:0]  M_WSTRB;
   logic        M_WVALID;
   logic        M_WREADY;
   logic [1:0]  M_BRESP;
   logic        M_BVALID;
   logic        M_BREADY;
   logic [31:0] M_ARADDR;
   logic [2:0]  M_ARPROT;
   logic        M_ARVALID;
   logic        M_ARREADY;
   logic [31:0] M_RDATA;
   logic [1:0]  M_RRESP;
   logic        M_RVALID;
   logic        M_RREADY;

   modport master (
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata, mem_err,
      output M_AWADDR, M_AWPROT, M_AWVALID, input M_AWREADY,
      output M_WDATA, M_WSTRB, M_WVALID, input M_WREADY,
      input  M_BRESP, M_BVALID, output M_BREADY,
      output M_ARADDR, M_ARPROT, M_ARVALID, input M_ARREADY,
      input  M_RDATA, M_RRESP, M_RVALID, output M_RREADY
   );

   modport slave (
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata, mem_err,
      input  M_AWADDR, M_AWPROT, M_AWVALID, output M_AWREADY,
      input  M_WDATA, M_WSTRB, M_WVALID, output M_WREADY,
      output M_BRESP, M_BVALID, input M_BREADY,
      input  M_ARADDR, M_ARPROT, M_ARVALID, output M_ARREADY,
      output M_RDATA, M_RRESP, M_RVALID, input M_RREADY
   );
endinterface

// File: rtl/axil_master_bridge.sv
// PicoRV32-style mem_valid/mem_ready to single-outstanding AXI-Lite master bridge.
// A response timeout completes the CPU access with an error; FLUSH then drains the AXI side.
module axil_master_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input logic                  aclk,
   input logic                  aresetn,
   axil_master_bridge_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_DONE, S_FLUSH
   } state_e;

   state_e      state_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [2:0]  prot_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        ready_q;
   logic        awvalid_q;
   logic        wvalid_q;
   logic        bready_q;
   logic        arvalid_q;
   logic        rready_q;
   logic [31:0] cnt_q;
   logic [31:0] cnt_d;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic wr_addr_done;
   logic expire;

   assign aw_hs = awvalid_q & bus.M_AWREADY;
   assign w_hs  = wvalid_q  & bus.M_WREADY;
   assign b_hs  = bready_q  & bus.M_BVALID;
   assign ar_hs = arvalid_q & bus.M_ARREADY;
   assign r_hs  = rready_q  & bus.M_RVALID;

   // AW and W may complete in either order or together
   assign wr_addr_done = (aw_hs | ~awvalid_q) & (w_hs | ~wvalid_q);

   assign cnt_d  = cnt_q + 32'd1;
   assign expire = (TIMEOUT_CYCLES != 0) && (cnt_d >= TIMEOUT_CYCLES);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         prot_q    <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         ready_q   <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         ready_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.mem_valid) begin
                  addr_q  <= bus.mem_addr;
                  wdata_q <= bus.mem_wdata;
                  wstrb_q <= bus.mem_wstrb;
                  prot_q  <= {bus.mem_instr, 2'b00};
                  cnt_q   <= '0;
                  if (|bus.mem_wstrb) begin
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= S_WADDR;
                  end else begin
                     arvalid_q <= 1'b1;
                     state_q   <= S_RADDR;
                  end
               end
            end

            S_WADDR: begin
               if (aw_hs) awvalid_q <= 1'b0;
               if (w_hs)  wvalid_q  <= 1'b0;
               if (wr_addr_done) begin
                  bready_q <= 1'b1;
                  cnt_q    <= cnt_d;
                  state_q  <= S_WRESP;
               end else if (expire) begin
                  ready_q  <= 1'b1;
                  err_q    <= 1'b1;
                  bready_q <= 1'b1;
                  state_q  <= S_FLUSH;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            S_WRESP: begin
               if (b_hs) begin
                  err_q    <= |bus.M_BRESP;
                  ready_q  <= 1'b1;
                  bready_q <= 1'b0;
                  state_q  <= S_DONE;
               end else if (expire) begin
                  ready_q <= 1'b1;
                  err_q   <= 1'b1;
                  state_q <= S_FLUSH;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            S_RADDR: begin
               if (ar_hs) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  cnt_q     <= cnt_d;
                  state_q   <= S_RDATA;
               end else if (expire) begin
                  ready_q  <= 1'b1;
                  err_q    <= 1'b1;
                  rdata_q  <= ERR_RDATA;
                  rready_q <= 1'b1;
                  state_q  <= S_FLUSH;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            S_RDATA: begin
               if (r_hs) begin
                  rdata_q  <= bus.M_RDATA;
                  err_q    <= |bus.M_RRESP;
                  ready_q  <= 1'b1;
                  rready_q <= 1'b0;
                  state_q  <= S_DONE;
               end else if (expire) begin
                  ready_q <= 1'b1;
                  err_q   <= 1'b1;
                  rdata_q <= ERR_RDATA;
                  state_q <= S_FLUSH;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            S_DONE: state_q <= S_IDLE;

            S_FLUSH: begin
               if (aw_hs) awvalid_q <= 1'b0;
               if (w_hs)  wvalid_q  <= 1'b0;
               if (ar_hs) arvalid_q <= 1'b0;
               // Consuming the late response ends the transaction on the AXI side
               if (b_hs || r_hs) begin
                  awvalid_q <= 1'b0;
                  wvalid_q  <= 1'b0;
                  arvalid_q <= 1'b0;
                  bready_q  <= 1'b0;
                  rready_q  <= 1'b0;
                  state_q   <= S_IDLE;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.mem_ready = ready_q;
   assign bus.mem_rdata = rdata_q;
   assign bus.mem_err   = err_q;

   assign bus.M_AWADDR  = addr_q;
   assign bus.M_AWPROT  = prot_q;
   assign bus.M_AWVALID = awvalid_q;
   assign bus.M_WDATA   = wdata_q;
   assign bus.M_WSTRB   = wstrb_q;
   assign bus.M_WVALID  = wvalid_q;
   assign bus.M_BREADY  = bready_q;
   assign bus.M_ARADDR  = addr_q;
   assign bus.M_ARPROT  = prot_q;
   assign bus.M_ARVALID = arvalid_q;
   assign bus.M_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_master_bridge.sv
// Directed bench for axil_master_bridge: table of single transactions against a
// configurable AXI-Lite slave, plus back-to-back, timeout/flush and mid-transfer reset sequences.
module tb_axil_master_bridge;

   logic clk = 1'b0;
   logic aresetn;
   int   checks   = 0;
   int   failures = 0;

   axil_master_bridge_if bus();

   axil_master_bridge #(
      .TIMEOUT_CYCLES(16),
      .ERR_RDATA     (32'hDEAD_BEEF)
   ) dut (
      .aclk   (clk),
      .aresetn(aresetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        instr;
      int          aw_dly;
      int          w_dly;
      int          ar_dly;
      int          resp_dly;
      logic [1:0]  resp;
      logic [31:0] rdata;
      int          exp_lat;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_aw;
      int          exp_w;
      int          exp_ar;
   } vec_t;

   vec_t vecs[6];

   // slave configuration (written by the test process only)
   logic [31:0] s_addr  = '0;
   logic [31:0] s_wdata = '0;
   logic [3:0]  s_wstrb = '0;
   logic [2:0]  s_prot  = '0;
   logic [31:0] s_rdata = '0;
   logic [1:0]  s_resp  = '0;
   logic        s_resp_en = 1'b1;
   int          s_aw_dly = 0, s_w_dly = 0, s_ar_dly = 0, s_resp_dly = 0;

   // slave observation counters (written by the slave process only)
   int n_aw = 0, n_w = 0, n_ar = 0, n_bhs = 0, n_rhs = 0, n_bad = 0, n_ovl = 0;
   int aw_c = 0, w_c = 0, ar_c = 0, rt = 0;
   logic aw_done = 1'b0, w_done = 1'b0, ar_done = 1'b0;

   always @(negedge clk) begin
      if (!aresetn) begin
         aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0;
         aw_c = 0; w_c = 0; ar_c = 0; rt = 0;
         bus.M_AWREADY = 1'b0; bus.M_WREADY = 1'b0; bus.M_ARREADY = 1'b0;
         bus.M_BVALID = 1'b0; bus.M_BRESP = 2'b00;
         bus.M_RVALID = 1'b0; bus.M_RRESP = 2'b00; bus.M_RDATA = '0;
      end else begin
         if (aw_done && w_done) begin
            bus.M_BVALID = s_resp_en && (rt >= s_resp_dly);
            bus.M_BRESP  = s_resp;
            rt++;
            if (bus.M_BVALID && bus.M_BREADY) begin
               n_bhs++; aw_done = 1'b0; w_done = 1'b0; rt = 0;
            end
         end else if (ar_done) begin
            bus.M_BVALID = 1'b0;
         end else begin
            bus.M_BVALID = 1'b0;
         end

         if (ar_done) begin
            bus.M_RVALID = s_resp_en && (rt >= s_resp_dly);
            bus.M_RRESP  = s_resp;
            bus.M_RDATA  = s_rdata;
            rt++;
            if (bus.M_RVALID && bus.M_RREADY) begin
               n_rhs++; ar_done = 1'b0; rt = 0;
            end
         end else begin
            bus.M_RVALID = 1'b0;
         end

         if ((bus.M_AWVALID || bus.M_WVALID) && bus.M_ARVALID) n_ovl++;

         if (bus.M_AWVALID) begin
            n_aw++;
            if (aw_done || bus.M_AWADDR !== s_addr || bus.M_AWPROT !== s_prot) n_bad++;
            bus.M_AWREADY = (aw_c >= s_aw_dly);
            aw_c++;
            if (bus.M_AWREADY) begin aw_done = 1'b1; aw_c = 0; end
         end else begin
            bus.M_AWREADY = 1'b0;
         end

         if (bus.M_WVALID) begin
            n_w++;
            if (w_done || bus.M_WDATA !== s_wdata || bus.M_WSTRB !== s_wstrb) n_bad++;
            bus.M_WREADY = (w_c >= s_w_dly);
            w_c++;
            if (bus.M_WREADY) begin w_done = 1'b1; w_c = 0; end
         end else begin
            bus.M_WREADY = 1'b0;
         end

         if (bus.M_ARVALID) begin
            n_ar++;
            if (ar_done || bus.M_ARADDR !== s_addr || bus.M_ARPROT !== s_prot) n_bad++;
            bus.M_ARREADY = (ar_c >= s_ar_dly);
            ar_c++;
            if (bus.M_ARREADY) begin ar_done = 1'b1; ar_c = 0; end
         end else begin
            bus.M_ARREADY = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_req(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic instr);
      bus.mem_addr  = addr;
      bus.mem_wdata = wdata;
      bus.mem_wstrb = wstrb;
      bus.mem_instr = instr;
      bus.mem_valid = 1'b1;
   endtask

   task automatic run_txn(input vec_t v, input string tag);
      int lat;
      int aw0, w0, ar0, hs0, bad0, ovl0;
      s_addr = v.addr; s_wdata = v.wdata; s_wstrb = v.wstrb; s_prot = {v.instr, 2'b00};
      s_rdata = v.rdata; s_resp = v.resp; s_resp_en = 1'b1;
      s_aw_dly = v.aw_dly; s_w_dly = v.w_dly; s_ar_dly = v.ar_dly; s_resp_dly = v.resp_dly;
      aw0 = n_aw; w0 = n_w; ar0 = n_ar; hs0 = n_bhs + n_rhs; bad0 = n_bad; ovl0 = n_ovl;
      drive_req(v.addr, v.wdata, v.wstrb, v.instr);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!bus.mem_ready && lat < 60);
      bus.mem_valid = 1'b0;
      check({tag, ".latency"}, lat, v.exp_lat);
      check({tag, ".mem_err"}, 32'(bus.mem_err), 32'(v.exp_err));
      check({tag, ".mem_rdata"}, bus.mem_rdata, v.exp_rdata);
      check({tag, ".awvalid_cycles"}, n_aw - aw0, v.exp_aw);
      check({tag, ".wvalid_cycles"}, n_w - w0, v.exp_w);
      check({tag, ".arvalid_cycles"}, n_ar - ar0, v.exp_ar);
      check({tag, ".resp_handshakes"}, n_bhs + n_rhs - hs0, 1);
      check({tag, ".payload_errors"}, n_bad - bad0, 0);
      check({tag, ".aw_ar_overlap"}, n_ovl - ovl0, 0);
      @(posedge clk); #1;
      check({tag, ".single_pulse"}, 32'(bus.mem_ready), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r1, r2, extra, rr_drop, early_aw, aw32, hs0, ovl0, pulses, lat;
      logic e1, e2;
      logic [31:0] d1, d2;

      //            addr          wdata         strb  ins aw w ar rsp resp   rdata         lat err exp_rdata    aw w ar
      vecs[0] = '{32'h4000_0004, 32'h0000_A5A5, 4'hF, 1'b0, 0, 0, 0, 0, 2'b00, 32'h0,         3, 1'b0, 32'h0,         1, 1, 0};
      vecs[1] = '{32'h4000_0004, 32'h0000_A5A5, 4'hF, 1'b0, 3, 0, 0, 0, 2'b00, 32'h0,         6, 1'b0, 32'h0,         4, 1, 0};
      vecs[2] = '{32'h4000_0000, 32'h0,         4'h0, 1'b1, 0, 0, 0, 0, 2'b00, 32'h1234_5678, 3, 1'b0, 32'h1234_5678, 0, 0, 1};
      vecs[3] = '{32'h4000_0000, 32'h0,         4'h0, 1'b1, 0, 0, 0, 0, 2'b11, 32'h1234_5678, 3, 1'b1, 32'h1234_5678, 0, 0, 1};
      vecs[4] = '{32'h4000_0010, 32'h1122_3344, 4'h3, 1'b0, 0, 2, 0, 1, 2'b10, 32'h0,         6, 1'b1, 32'h1234_5678, 1, 3, 0};
      vecs[5] = '{32'h4000_0020, 32'h0,         4'h0, 1'b0, 0, 0, 2, 2, 2'b10, 32'hCAFE_F00D, 7, 1'b1, 32'hCAFE_F00D, 0, 0, 3};

      aresetn = 1'b0;
      bus.mem_valid = 1'b0; bus.mem_instr = 1'b0;
      bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_wstrb = '0;
      #1;
      check("rst.mem_ready", 32'(bus.mem_ready), 0);
      check("rst.mem_err", 32'(bus.mem_err), 0);
      check("rst.mem_rdata", bus.mem_rdata, 0);
      check("rst.awvalid", 32'(bus.M_AWVALID), 0);
      check("rst.wvalid", 32'(bus.M_WVALID), 0);
      check("rst.arvalid", 32'(bus.M_ARVALID), 0);
      check("rst.bready", 32'(bus.M_BREADY), 0);
      check("rst.rready", 32'(bus.M_RREADY), 0);
      check("rst.awaddr", bus.M_AWADDR, 0);
      #21 aresetn = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

      // Back-to-back: read held on mem_valid through the write's DONE cycle
      s_addr = 32'h4000_0030; s_wdata = 32'h55AA_55AA; s_wstrb = 4'hF; s_prot = 3'b000;
      s_rdata = 32'h0BAD_F00D; s_resp = 2'b00; s_resp_en = 1'b1;
      s_aw_dly = 0; s_w_dly = 0; s_ar_dly = 0; s_resp_dly = 0;
      hs0 = n_bhs + n_rhs; ovl0 = n_ovl; pulses = 0; lat = 0;
      drive_req(32'h4000_0030, 32'h55AA_55AA, 4'hF, 1'b0);
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (bus.mem_ready) begin
            pulses++;
            if (c == 3) begin
               check("b2b.wr_err", 32'(bus.mem_err), 0);
               bus.mem_addr = 32'h4000_0040; bus.mem_wstrb = 4'h0;
               s_addr = 32'h4000_0040;
            end else begin
               lat = c;
            end
         end
         if (c == 4) check("b2b.ar_not_in_idle_cycle", 32'(bus.M_ARVALID), 0);
         if (c == 5) check("b2b.ar_after_idle", 32'(bus.M_ARVALID), 1);
         if (lat != 0) bus.mem_valid = 1'b0;
      end
      check("b2b.rd_ready_cycle", lat, 7);
      check("b2b.pulses", pulses, 2);
      check("b2b.rd_data", bus.mem_rdata, 32'h0BAD_F00D);
      check("b2b.handshakes", n_bhs + n_rhs - hs0, 2);
      check("b2b.overlap", n_ovl - ovl0, 0);

      // Timeout: slave withholds RVALID until cycle 30; a write is queued from cycle 20
      s_addr = 32'h4000_0008; s_prot = 3'b000; s_rdata = 32'h7777_7777; s_resp = 2'b00;
      s_resp_en = 1'b0; s_ar_dly = 0; s_resp_dly = 0;
      hs0 = n_rhs; r1 = 0; r2 = 0; extra = 0; rr_drop = 0; early_aw = 0; aw32 = 0;
      e1 = 1'b0; e2 = 1'b0; d1 = '0; d2 = '0;
      drive_req(32'h4000_0008, 32'h0, 4'h0, 1'b0);
      for (int c = 1; c <= 34; c++) begin
         @(posedge clk); #1;
         if (c == 1) bus.mem_valid = 1'b0;
         if (bus.mem_ready) begin
            if (r1 == 0) begin r1 = c; e1 = bus.mem_err; d1 = bus.mem_rdata; end
            else if (r2 == 0) begin r2 = c; e2 = bus.mem_err; d2 = bus.mem_rdata; end
            else extra++;
         end
         if (c >= 18 && c <= 30 && !bus.M_RREADY) rr_drop++;
         if (c >= 20 && c <= 31 && bus.M_AWVALID) early_aw++;
         if (c == 20) begin
            s_addr = 32'h4000_0050; s_wdata = 32'h0000_0001; s_wstrb = 4'hF;
            drive_req(32'h4000_0050, 32'h0000_0001, 4'hF, 1'b0);
         end
         if (c == 30) s_resp_en = 1'b1;
         if (c == 32) aw32 = 32'(bus.M_AWVALID);
      end
      bus.mem_valid = 1'b0;
      check("tmo.ready_cycle", r1, 17);
      check("tmo.err", 32'(e1), 1);
      check("tmo.rdata", d1, 32'hDEAD_BEEF);
      check("tmo.rready_held", rr_drop, 0);
      check("tmo.flush_blocks_req", early_aw, 0);
      check("tmo.aw_after_flush", aw32, 1);
      check("tmo.late_r_consumed", n_rhs - hs0, 1);
      check("tmo.next_ready_cycle", r2, 34);
      check("tmo.next_err", 32'(e2), 0);
      check("tmo.next_rdata_kept", d2, 32'hDEAD_BEEF);
      check("tmo.extra_pulses", extra, 0);
      @(posedge clk); #1;

      // Asynchronous reset while ARVALID is pending
      s_addr = 32'h4000_0060; s_prot = 3'b000; s_ar_dly = 20; s_resp_en = 1'b1;
      drive_req(32'h4000_0060, 32'h0, 4'h0, 1'b0);
      @(posedge clk); #1;
      check("arst.arvalid_before", 32'(bus.M_ARVALID), 1);
      @(posedge clk); #3;
      aresetn = 1'b0;
      bus.mem_valid = 1'b0;
      #1;
      check("arst.arvalid", 32'(bus.M_ARVALID), 0);
      check("arst.awvalid", 32'(bus.M_AWVALID), 0);
      check("arst.wvalid", 32'(bus.M_WVALID), 0);
      check("arst.bready", 32'(bus.M_BREADY), 0);
      check("arst.rready", 32'(bus.M_RREADY), 0);
      check("arst.mem_ready", 32'(bus.mem_ready), 0);
      #10 aresetn = 1'b1;
      extra = 0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (bus.mem_ready || bus.M_ARVALID) extra++;
      end
      check("arst.quiet_after_release", extra, 0);
      check("arst.mem_rdata", bus.mem_rdata, 0);
      check("arst.mem_err", 32'(bus.mem_err), 0);
      run_txn(vecs[2], "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
